// File: rtl/alu_program_sequencer.sv
// alu_program_sequencer: fetches ROM instructions and issues operator/operand pairs to the ALU/register unit, capturing READ results.
module alu_program_sequencer #(
  parameter int ADDR_W = 8,
  parameter int MAX_INSTR = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [15:0]       operator,
  output logic [15:0]       operand,
  input  logic [15:0]       reg_read_data,
  input  logic [3:0]        alu_flags,
  output logic [15:0]       result_data,
  output logic              result_valid
);
  localparam int CW = $clog2(MAX_INSTR + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_CAPTURE, S_END} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] instr_q, instr_d;
  logic error_q, error_d, result_valid_q, result_valid_d;
  logic [15:0] result_data_q, result_data_d;
  logic [7:0] opc;
  logic halt, jmp, jz, is_read, internal, wd, unused_flags;
  assign opc = instr_q[31:24];
  assign tgt = instr_q[ADDR_W-1:0];
  assign halt = opc == 8'hF0;
  assign jmp = opc == 8'hF1;
  assign jz = opc == 8'hF2;
  assign is_read = opc == 8'h12;
  assign internal = halt || jmp || jz;
  assign cnt_inc = cnt_q + CW'(1);
  assign wd = cnt_inc >= CW'(MAX_INSTR);
  assign unused_flags = ^alu_flags[3:1];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    instr_d = instr_q;
    error_d = error_q;
    result_data_d = result_data_q;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        pc_d = '0;
        cnt_d = '0;
        error_d = 1'b0;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = prog_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        pc_d = halt ? pc_q : (jmp || (jz && alu_flags[0])) ? tgt : pc_q + ADDR_W'(1);
        error_d = !halt && wd;
        state_d = (halt || wd) ? S_END : is_read ? S_CAPTURE : S_FETCH;
      end
      S_CAPTURE: begin
        result_data_d = reg_read_data;
        result_valid_d = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      cnt_q <= '0;
      instr_q <= '0;
      error_q <= 1'b0;
      result_data_q <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      instr_q <= instr_d;
      error_q <= error_d;
      result_data_q <= result_data_d;
      result_valid_q <= result_valid_d;
    end
  end
  // HALT/JMP/JZ are consumed here, so the unit only ever sees NOP for them
  assign operator = (state_q == S_ISSUE && !internal) ? instr_q[31:16] : 16'hFF00;
  assign operand = (state_q == S_ISSUE && !internal) ? instr_q[15:0] : 16'h0000;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_END;
  assign error = error_q;
  assign prog_addr = pc_q;
  assign result_data = result_data_q;
  assign result_valid = result_valid_q;
endmodule

// File: tb/tb_alu_program_sequencer.sv
// tb_alu_program_sequencer: random and directed programs checked against a program-level interpreter.
module tb_alu_program_sequencer;
  localparam int AW = 4, MI = 8;
  logic clk = 1'b0, reset, start;
  logic busy, done, error, result_valid;
  logic [AW-1:0] prog_addr;
  logic [31:0] prog_data;
  logic [15:0] operator, operand, reg_read_data, result_data;
  logic [3:0] alu_flags;
  logic [31:0] rom [16];
  logic [15:0] e_regs [8];
  logic e_zero;
  logic [15:0] m_regs [8];
  logic m_zero;
  logic [31:0] exp_ops [$], obs_ops [$];
  int exp_oc [$], obs_oc [$], exp_rc [$], obs_rc [$];
  logic [15:0] exp_res [$], obs_res [$];
  int exp_done_c, obs_done_c, busy_bad, saw_wrap, saw_internal, addr_moved;
  logic exp_err, obs_err;
  int n_assert = 0, n_fail = 0;

  alu_program_sequencer #(.ADDR_W(AW), .MAX_INSTR(MI)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .prog_addr(prog_addr), .prog_data(prog_data), .operator(operator), .operand(operand),
    .reg_read_data(reg_read_data), .alu_flags(alu_flags),
    .result_data(result_data), .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) prog_data <= rom[prog_addr];

  function automatic logic [15:0] alu(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 8'h00) return a + b;
    if (op == 8'h01) return a - b;
    if (op == 8'h02) return a & b;
    if (op == 8'h03) return a | b;
    return a ^ b;
  endfunction

  // Behavioural ALU/register unit: dst = operator[2:0], sources = operand[10:8], operand[2:0]
  assign alu_flags = {3'b000, e_zero};
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) e_regs[i] <= '0;
      e_zero <= 1'b0;
      reg_read_data <= '0;
    end else begin
      reg_read_data <= e_regs[operator[2:0]];
      if (operator[15:8] <= 8'h04) begin
        e_regs[operator[2:0]] <= alu(operator[15:8], e_regs[operand[10:8]], e_regs[operand[2:0]]);
        e_zero <= alu(operator[15:8], e_regs[operand[10:8]], e_regs[operand[2:0]]) == 16'h0;
      end else if (operator[15:8] == 8'h11) e_regs[operator[2:0]] <= operand;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_zero = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 32'hF000_0000;
  endtask

  // Interprets the program instruction by instruction and predicts the cycle of every visible event
  task automatic model_run();
    int pc, npc, cnt, t;
    logic [31:0] w;
    logic [15:0] r;
    exp_ops.delete(); exp_oc.delete(); exp_res.delete(); exp_rc.delete();
    pc = 0; cnt = 0; t = 3;
    forever begin
      w = rom[pc];
      cnt++;
      if (w[31:24] == 8'hF0) begin exp_done_c = t + 1; exp_err = 1'b0; return; end
      npc = (pc + 1) % 16;
      if (w[31:24] == 8'hF1) npc = int'(w[AW-1:0]);
      else if (w[31:24] == 8'hF2) begin if (m_zero) npc = int'(w[AW-1:0]); end
      else begin
        exp_ops.push_back(w);
        exp_oc.push_back(t);
        if (w[31:24] <= 8'h04) begin
          r = alu(w[31:24], m_regs[w[10:8]], m_regs[w[2:0]]);
          m_regs[w[18:16]] = r;
          m_zero = r == 16'h0;
        end else if (w[31:24] == 8'h11) m_regs[w[18:16]] = w[15:0];
        else if (w[31:24] == 8'h12) begin
          exp_res.push_back(m_regs[w[18:16]]);
          exp_rc.push_back(t + 2);
        end
      end
      if (cnt == MI) begin exp_done_c = t + 1; exp_err = 1'b1; return; end
      t += (w[31:24] == 8'h12) ? 4 : 3;
      pc = npc;
    end
  endtask

  task automatic run_dut(input int glitch);
    logic [AW-1:0] prev;
    obs_ops.delete(); obs_oc.delete(); obs_res.delete(); obs_rc.delete();
    obs_done_c = -1; obs_err = 1'bx; busy_bad = 0; saw_wrap = 0; saw_internal = 0; addr_moved = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    prev = prog_addr;
    for (int c = 1; c <= 300; c++) begin
      if (operator !== 16'hFF00) begin
        obs_ops.push_back({operator, operand});
        obs_oc.push_back(c);
        if (operator[15:8] inside {8'hF0, 8'hF1, 8'hF2}) saw_internal++;
      end
      if (result_valid === 1'b1) begin obs_res.push_back(result_data); obs_rc.push_back(c); end
      if (prev == AW'(15) && prog_addr == AW'(0)) saw_wrap++;
      if (prog_addr !== AW'(0)) addr_moved++;
      prev = prog_addr;
      start = (c == glitch);
      if (done === 1'b1) begin obs_done_c = c; obs_err = error; break; end
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name);
    chk({name, " done_cycle"}, 64'(obs_done_c), 64'(exp_done_c));
    chk({name, " error"}, 64'(obs_err), 64'(exp_err));
    chk({name, " busy_gap"}, 64'(busy_bad), 64'd0);
    chk({name, " internal_op_seen"}, 64'(saw_internal), 64'd0);
    chk({name, " issue_count"}, 64'(obs_ops.size()), 64'(exp_ops.size()));
    chk({name, " result_count"}, 64'(obs_res.size()), 64'(exp_res.size()));
    for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++) begin
      chk({name, " issue_word"}, 64'(obs_ops[i]), 64'(exp_ops[i]));
      chk({name, " issue_cycle"}, 64'(obs_oc[i]), 64'(exp_oc[i]));
    end
    for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
      chk({name, " result_data"}, 64'(obs_res[i]), 64'(exp_res[i]));
      chk({name, " result_cycle"}, 64'(obs_rc[i]), 64'(exp_rc[i]));
    end
    @(negedge clk);
    chk({name, " busy_after"}, 64'(busy), 64'd0);
    chk({name, " done_after"}, 64'(done), 64'd0);
    chk({name, " nop_after"}, 64'(operator), 64'hFF00);
  endtask

  task automatic load_basic(input logic [31:0] alu_word);
    clear_rom();
    rom[0] = 32'h1101_0004;
    rom[1] = 32'h1102_0005;
    rom[2] = alu_word;
    rom[3] = 32'h1203_0000;
  endtask

  initial begin
    logic [2:0] d3, a3, b3;
    int n;
    start = 1'b0;
    reset = 1'b1;
    clear_rom();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset error", 64'(error), 64'd0);
    chk("reset result_valid", 64'(result_valid), 64'd0);
    chk("reset result_data", 64'(result_data), 64'd0);
    chk("reset prog_addr", 64'(prog_addr), 64'd0);
    chk("reset operator", 64'(operator), 64'hFF00);
    chk("reset operand", 64'(operand), 64'd0);

    load_basic(32'h0403_0201);
    model_run(); run_dut(0); check_run("xor");
    chk("xor result=1", 64'(obs_res.size() > 0 ? obs_res[0] : 16'hDEAD), 64'd1);

    load_basic(32'h0003_0201);
    model_run(); run_dut(0); check_run("add");
    chk("add result=9", 64'(obs_res.size() > 0 ? obs_res[0] : 16'hDEAD), 64'd9);
    chk("add first_issue_cycle", 64'(obs_oc.size() > 0 ? obs_oc[0] : -1), 64'd3);
    chk("add read_to_valid", 64'(obs_rc.size() > 0 && obs_oc.size() > 3 ? obs_rc[0] - obs_oc[3] : -1), 64'd2);

    clear_rom();
    rom[0] = 32'h0103_0101; rom[1] = 32'hF200_000A;
    rom[2] = 32'h1201_0000; rom[10] = 32'h1203_0000;
    model_run(); run_dut(0); check_run("jz_taken");

    clear_rom();
    rom[0] = 32'hF200_000E; rom[1] = 32'hF000_0000;
    rom[14] = 32'h1105_0007; rom[15] = 32'h0406_0500;
    model_run(); run_dut(0); check_run("wrap");
    chk("wrap prog_addr 15->0", 64'(saw_wrap), 64'd1);

    clear_rom();
    rom[0] = 32'h0103_0201; rom[1] = 32'hF200_000A;
    rom[2] = 32'h1203_0000; rom[10] = 32'h1201_0000;
    model_run(); run_dut(0); check_run("jz_fallthrough");

    clear_rom();
    rom[0] = 32'hF100_0000;
    model_run(); run_dut(0); check_run("watchdog");
    chk("watchdog prog_addr_moves", 64'(addr_moved), 64'd0);
    repeat (4) @(negedge clk);
    chk("watchdog error_sticky", 64'(error), 64'd1);
    chk("watchdog prog_addr_idle", 64'(prog_addr), 64'd0);

    load_basic(32'h0403_0201);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("midreset operator", 64'(operator), 64'hFF00);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset prog_addr", 64'(prog_addr), 64'd0);
    chk("midreset error", 64'(error), 64'd0);
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    model_reset();
    @(negedge clk);
    chk("reset_beats_start busy", 64'(busy), 64'd0);

    model_run(); run_dut(7); check_run("start_while_busy");

    for (int k = 0; k < 6; k++) begin
      clear_rom();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        d3 = 3'($urandom_range(1, 7)); a3 = 3'($urandom); b3 = 3'($urandom);
        case ($urandom_range(0, 2))
          0: rom[i] = {8'h11, 5'd0, d3, 16'($urandom)};
          1: rom[i] = {8'($urandom_range(0, 4)), 5'd0, d3, 5'd0, a3, 5'd0, b3};
          default: rom[i] = {8'h12, 5'd0, d3, 16'h0};
        endcase
      end
      model_run(); run_dut(0); check_run($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
